vend_ctrl: RTL and testbench

VEND_CTRL -- requirements
Module: vend_ctrl

---
 rtl/vend_pkg.sv | 29 ++
 rtl/vend_ctrl_rr_arb4.sv | 41 ++++
 rtl/vend_ctrl.sv | 151 +++++++++++++++
 tb/tb_vend_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: shared types and constants for the vending controller.
//   state_e      - controller FSM states (IDLE, VEND, CHANGE)
//   DENOM_0..3   - coin denominations of slots 0..3 (1, 2, 5, 10)
//   denom_value  - maps a 2-bit slot/denomination index to its coin value
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2
  } state_e;

  localparam logic [3:0] DENOM_0 = 4'd1;
  localparam logic [3:0] DENOM_1 = 4'd2;
  localparam logic [3:0] DENOM_2 = 4'd5;
  localparam logic [3:0] DENOM_3 = 4'd10;

  function automatic logic [3:0] denom_value(input logic [1:0] idx);
    logic [3:0] v;
    case (idx)
      2'd0:    v = DENOM_0;
      2'd1:    v = DENOM_1;
      2'd2:    v = DENOM_2;
      default: v = DENOM_3;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vend_ctrl_rr_arb4.sv
// rr_arb4: 4-way round-robin arbiter for the coin slots.
//   clk_i, rst_ni - clock, asynchronous active-low reset (pointer -> slot0)
//   req_i         - per-slot requests
//   mask_i        - per-slot inhibit; a masked slot is skipped and never granted
//   en_i          - enables granting and the pointer update
//   gnt_o         - one-hot grant (or zero)
// The pointer names the highest-priority slot; after a grant it moves to the
// slot following the winner. No grant leaves the pointer untouched.
module rr_arb4 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] req_i,
  input  logic [3:0] mask_i,
  input  logic       en_i,
  output logic [3:0] gnt_o
);

  logic [1:0] ptr_q, ptr_d;
  logic [3:0] eff_req;
  logic [1:0] slot;

  always_comb begin
    eff_req = req_i & ~mask_i;
    gnt_o   = '0;
    ptr_d   = ptr_q;
    slot    = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      slot = ptr_q + k[1:0];
      if (en_i && (gnt_o == '0) && eff_req[slot]) begin
        gnt_o[slot] = 1'b1;
        ptr_d       = slot + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: vending-machine credit / dispense / change controller.
//   clk, arstn           - clock, asynchronous active-low reset
//   coin_req / coin_gnt  - coin slots 0..3 (1,2,5,10); one-hot accept
//   sel_valid/sel_price/sel_ready - product selection handshake
//   vend, err            - one-cycle dispense / insufficient-credit pulses
//   chg_valid/chg_coin/chg_ready  - change coin offer (denomination index)
//   credit, busy         - current credit; high outside IDLE
// Optional feature: define VEND_CANCEL_EN to add input `cancel`, which in IDLE
// with non-zero credit refunds the full credit as change (beats selection).
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned          PRICE_W    = 8,
  parameter logic [PRICE_W-1:0]   CREDIT_MAX = 8'd200
) (
  input  logic               clk,
  input  logic               arstn,
  input  logic [3:0]         coin_req,
  output logic [3:0]         coin_gnt,
  input  logic               sel_valid,
  input  logic [PRICE_W-1:0] sel_price,
  output logic               sel_ready,
  output logic               vend,
  output logic               err,
  output logic               chg_valid,
  output logic [1:0]         chg_coin,
  input  logic               chg_ready,
  output logic [PRICE_W-1:0] credit,
`ifdef VEND_CANCEL_EN
  input  logic               cancel,
`endif
  output logic               busy
);

  typedef logic [PRICE_W-1:0] credit_t;
  typedef logic [PRICE_W:0]   sum_t;

  state_e     state_q, state_d;
  credit_t    credit_q, credit_d;
  logic       err_q, err_d;
  logic [3:0] slot_mask;
  logic [3:0] arb_gnt;
  logic [3:0] gnt_value;
  logic       arb_en;
  logic       sel_hs;
  logic       cancel_go;
  logic       is_idle;
  logic [1:0] chg_idx;
  sum_t       sum_tmp;

  assign is_idle = (state_q == ST_IDLE);

`ifdef VEND_CANCEL_EN
  assign cancel_go = arstn && is_idle && cancel && (credit_q != '0);
`else
  assign cancel_go = 1'b0;
`endif

  // sel_ready and coin_gnt are combinational, so they are also gated by arstn
  // to keep every output low while reset is asserted.
  assign sel_ready = arstn && is_idle && !cancel_go;
  assign sel_hs    = sel_valid && sel_ready;
  assign arb_en    = arstn && is_idle && !sel_hs && !cancel_go;

  // Inhibit any slot whose coin would push credit past CREDIT_MAX.
  always_comb begin
    slot_mask = '0;
    sum_tmp   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      sum_tmp      = sum_t'(credit_q) + sum_t'(denom_value(i[1:0]));
      slot_mask[i] = (sum_tmp > sum_t'(CREDIT_MAX));
    end
  end

  rr_arb4 u_arb (
    .clk_i  (clk),
    .rst_ni (arstn),
    .req_i  (coin_req),
    .mask_i (slot_mask),
    .en_i   (arb_en),
    .gnt_o  (arb_gnt)
  );

  always_comb begin
    gnt_value = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (arb_gnt[i]) gnt_value = denom_value(i[1:0]);
    end
  end

  // Largest denomination not exceeding the remaining credit.
  always_comb begin
    if      (credit_q >= credit_t'(DENOM_3)) chg_idx = 2'd3;
    else if (credit_q >= credit_t'(DENOM_2)) chg_idx = 2'd2;
    else if (credit_q >= credit_t'(DENOM_1)) chg_idx = 2'd1;
    else                                     chg_idx = 2'd0;
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cancel_go) begin
          state_d = ST_CHANGE;
        end else if (sel_hs) begin
          if (credit_q >= sel_price) begin
            state_d  = ST_VEND;
            credit_d = credit_q - sel_price;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          credit_d = credit_q + credit_t'(gnt_value);
        end
      end
      ST_VEND: begin
        state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        if (chg_ready) begin
          credit_d = credit_q - credit_t'(denom_value(chg_idx));
          if (credit_d == '0) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  assign coin_gnt  = arb_gnt;
  assign vend      = (state_q == ST_VEND);
  assign err       = err_q;
  assign chg_valid = (state_q == ST_CHANGE);
  assign chg_coin  = chg_valid ? chg_idx : 2'd0;
  assign credit    = credit_q;
  assign busy      = !is_idle;

endmodule

// File: tb/tb_vend_ctrl.sv
`timescale 1ns/1ps
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       arstn;
  logic [3:0] coin_req;
  logic [3:0] coin_gnt;
  logic       sel_valid;
  logic [7:0] sel_price;
  logic       sel_ready;
  logic       vend;
  logic       err;
  logic       chg_valid;
  logic [1:0] chg_coin;
  logic       chg_ready;
  logic [7:0] credit;
  logic       busy;
`ifdef VEND_CANCEL_EN
  logic       cancel;
`endif

  always #5 clk = ~clk;

  vend_ctrl #(.PRICE_W(8), .CREDIT_MAX(8'd200)) dut (
    .clk       (clk),
    .arstn     (arstn),
    .coin_req  (coin_req),
    .coin_gnt  (coin_gnt),
    .sel_valid (sel_valid),
    .sel_price (sel_price),
    .sel_ready (sel_ready),
    .vend      (vend),
    .err       (err),
    .chg_valid (chg_valid),
    .chg_coin  (chg_coin),
    .chg_ready (chg_ready),
    .credit    (credit),
`ifdef VEND_CANCEL_EN
    .cancel    (cancel),
`endif
    .busy      (busy)
  );

  typedef enum int {K_GNT, K_VEND, K_ERR, K_CHG} kind_e;
  typedef struct {
    kind_e      kind;
    logic [3:0] val;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic push(input kind_e k, input logic [3:0] v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic mon_event(input kind_e k, input logic [3:0] v);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL unexpected_%s: got val %0d want no event at %0t", k.name(), v, $time);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.val != v) begin
        bad++;
        $display("FAIL event: got %s/%0d want %s/%0d at %0t", k.name(), v, e.kind.name(), e.val, $time);
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output event.
  always @(negedge clk) begin
    if (arstn) begin
      if (coin_gnt != 4'b0000) mon_event(K_GNT, coin_gnt);
      if (vend)                mon_event(K_VEND, 4'd0);
      if (err)                 mon_event(K_ERR, 4'd0);
      if (chg_valid) begin
        total++;
        if (sb.size() == 0 || sb[0].kind != K_CHG || sb[0].val != {2'b00, chg_coin}) begin
          bad++;
          $display("FAIL chg_hold: got chg_coin %0d want front %0d (queue %0d) at %0t",
                   chg_coin, (sb.size() != 0) ? sb[0].val : 4'hF, sb.size(), $time);
        end
        if (chg_ready) mon_event(K_CHG, {2'b00, chg_coin});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check(nm, int'(busy), 0);
  endtask

  task automatic wait_chg(input string nm);
    int n = 0;
    while (!chg_valid && n < 50) begin
      tick();
      n++;
    end
    check(nm, int'(chg_valid), 1);
  endtask

  task automatic select(input logic [7:0] price);
    sel_valid = 1'b1;
    sel_price = price;
    tick();
    sel_valid = 1'b0;
    sel_price = '0;
  endtask

  initial begin
    arstn     = 1'b0;
    coin_req  = '0;
    sel_valid = 1'b0;
    sel_price = '0;
    chg_ready = 1'b1;
`ifdef VEND_CANCEL_EN
    cancel    = 1'b0;
`endif
    #12;
    check("rst_credit", credit, 0);
    check("rst_busy", busy, 0);
    check("rst_sel_ready", sel_ready, 0);
    check("rst_gnt", coin_gnt, 0);
    tick();
    arstn = 1'b1;
    tick();
    check("idle_sel_ready", sel_ready, 1);

    // Round robin on slots 0,1: grants 0,1,0 -> credit 4
    coin_req = 4'b0011;
    push(K_GNT, 4'b0001); push(K_GNT, 4'b0010); push(K_GNT, 4'b0001);
    repeat (3) tick();
    coin_req = '0;
    check("rr_credit4", credit, 4);

    // Credit 6, price 4 -> vend, change 2 (index 1), back to IDLE
    coin_req = 4'b0010;
    push(K_GNT, 4'b0010);
    tick();
    coin_req = '0;
    check("credit6", credit, 6);
    push(K_VEND, 4'd0); push(K_CHG, 4'd1);
    select(8'd4);
    check("vend_busy", busy, 1);
    check("vend_credit2", credit, 2);
    wait_idle("vend6_idle");
    check("vend6_credit0", credit, 0);

    // Credit 3, price 5 -> err, coin request during handshake is not granted
    coin_req = 4'b0011;
    push(K_GNT, 4'b0001); push(K_GNT, 4'b0010);
    repeat (2) tick();
    check("credit3", credit, 3);
    coin_req = 4'b0001;
    push(K_ERR, 4'd0);
    select(8'd5);
    coin_req = '0;
    check("err_pulse", err, 1);
    check("err_credit3", credit, 3);
    check("err_busy", busy, 0);
    tick();
    check("err_one_cycle", err, 0);

    // Credit 17 vended at price 0, change 10,5,2 with dispenser stalled
    coin_req = 4'b1000;
    push(K_GNT, 4'b1000);
    tick();
    coin_req = 4'b0010;
    push(K_GNT, 4'b0010); push(K_GNT, 4'b0010);
    repeat (2) tick();
    coin_req = '0;
    check("credit17", credit, 17);
    chg_ready = 1'b0;
    push(K_VEND, 4'd0); push(K_CHG, 4'd3); push(K_CHG, 4'd2); push(K_CHG, 4'd1);
    select(8'd0);
    wait_chg("chg17_valid");
    repeat (3) tick();
    check("chg17_stall_credit", credit, 17);
    chg_ready = 1'b1;
    wait_idle("chg17_idle");
    check("chg17_credit0", credit, 0);

    // Credit limit: 195 + 10 withheld, 195 + 5 granted, 200 + 1 withheld
    coin_req = 4'b1000;
    for (int i = 0; i < 19; i++) push(K_GNT, 4'b1000);
    repeat (19) tick();
    coin_req = 4'b0100;
    push(K_GNT, 4'b0100);
    tick();
    check("credit195", credit, 195);
    coin_req = 4'b1000;
    repeat (2) tick();
    check("max_withheld", credit, 195);
    coin_req = 4'b0100;
    push(K_GNT, 4'b0100);
    tick();
    check("credit200", credit, 200);
    coin_req = 4'b0001;
    tick();
    coin_req = '0;
    check("max_hold200", credit, 200);
    push(K_VEND, 4'd0);
    select(8'd200);
    wait_idle("vend200_idle");
    check("vend200_credit0", credit, 0);

    // Reset in CHANGE with credit 7
    coin_req = 4'b0110;
    push(K_GNT, 4'b0010); push(K_GNT, 4'b0100);
    repeat (2) tick();
    coin_req = '0;
    check("credit7", credit, 7);
    chg_ready = 1'b0;
    push(K_VEND, 4'd0); push(K_CHG, 4'd2);
    select(8'd0);
    wait_chg("chg7_valid");
    coin_req  = 4'b1111;
    sel_valid = 1'b1;
    arstn     = 1'b0;
    #2;
    check("arst_chg_valid", chg_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_credit", credit, 0);
    check("arst_vend", vend, 0);
    check("arst_gnt", coin_gnt, 0);
    check("arst_sel_ready", sel_ready, 0);
    check("arst_pending", sb.size(), 1);
    sb.delete();
    tick();
    coin_req  = '0;
    sel_valid = 1'b0;
    chg_ready = 1'b1;
    arstn     = 1'b1;
    tick();
    coin_req = 4'b0011;
    push(K_GNT, 4'b0001);
    tick();
    coin_req = '0;
    check("post_rst_credit1", credit, 1);

`ifdef VEND_CANCEL_EN
    // Cancel at credit 8 refunds 5,2,1 and beats a concurrent selection
    coin_req = 4'b0100;
    push(K_GNT, 4'b0100);
    tick();
    coin_req = 4'b0010;
    push(K_GNT, 4'b0010);
    tick();
    coin_req = '0;
    check("credit8", credit, 8);
    push(K_CHG, 4'd2); push(K_CHG, 4'd1); push(K_CHG, 4'd0);
    cancel = 1'b1;
    select(8'd1);
    cancel = 1'b0;
    wait_idle("cancel_idle");
    check("cancel_credit0", credit, 0);
`endif

    tick();
    tick();
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
